spi_receiver: RTL and testbench

Receive-side SPI peripheral for the OLED/SPI path: it deserialises the `spi_clk`/`spi_data` stream produced by our SPI controller back into bytes. It is used as a loop-back checker in hardware, and as the command sink of an on-FPGA display model. It oversamples both SPI lines in the 100 MHz system domain, assembles MSB-first bytes, and buffers them in a small FIFO with a valid/ready output. It also flags truncated bytes and FIFO overruns.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_rx_fifo.sv | 40 ++++
 rtl/spi_receiver.sv | 122 ++++++++++++
 tb/tb_spi_receiver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: constants and FSM encoding shared by the SPI receiver and controller
package spi_pkg;
    localparam int SPI_BITS     = 8;
    localparam int SPI_SCK_HALF = 5;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;
endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: synchronous FIFO with MSB-wrap pointers, write allowed when full if a pop coincides
module spi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;
    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_data  = r_mem[r_rd[AW-1:0]];
    // storage and pointer update; entries cleared on reset so the head reads 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr <= r_wr + 1'b1;
            end
            if (w_rd) r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/spi_receiver.sv
// spi_receiver: oversampled SPI byte deserialiser with output FIFO, overrun and frame-error flags
module spi_receiver
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                spi_clk,
    input  logic                spi_data,
    output logic [SPI_BITS-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                overrun,
    input  logic                clear_overrun,
    output logic                frame_err,
    output logic                busy
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int BW = $clog2(SPI_BITS + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
    localparam logic [BW-1:0] LAST_BIT = BW'(SPI_BITS - 1);
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_sck_prev;
    logic [IW-1:0]          r_idle_cnt;
    logic [1:0]             r_state;
    logic [BW-1:0]          r_bit_cnt;
    logic [SPI_BITS-1:0]    r_shift;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_sck;
    logic                   w_sd;
    logic                   w_rise;
    logic                   w_timeout;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [SPI_BITS-1:0]    w_shift_next;
    assign w_sck        = r_sck_sync[SYNC_STAGES-1];
    assign w_sd         = r_sd_sync[SYNC_STAGES-1];
    assign w_rise       = w_sck && !r_sck_prev;
    assign w_timeout    = r_idle_cnt == IDLE_MAX;
    assign w_push       = r_state == ST_PUSH;
    assign w_pop        = m_valid && m_ready;
    assign w_shift_next = {r_shift[SPI_BITS-2:0], w_sd};
    assign m_valid      = !w_empty;
    assign busy         = r_state == ST_RECV;
    assign frame_err    = r_frame_err;
    assign overrun      = r_overrun;
    // synchronisers; clock side resets to its idle-high level so release never fakes a rise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sck_sync <= '1;
            r_sd_sync  <= '0;
            r_sck_prev <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk};
            r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], spi_data};
            r_sck_prev <= w_sck;
        end
    end
    // count consecutive high samples of the SPI clock, saturating at the timeout
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_idle_cnt <= '0;
        else if (!w_sck) r_idle_cnt <= '0;
        else if (!w_timeout) r_idle_cnt <= r_idle_cnt + 1'b1;
    end
    // byte assembly FSM; IDLE and PUSH both start a new byte on a rise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_RECV: begin
                    if (w_rise) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) r_state <= ST_PUSH;
                    end else if (w_timeout) begin
                        r_bit_cnt   <= '0;
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    if (w_rise) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= BW'(1);
                        r_state   <= ST_RECV;
                    end else begin
                        r_bit_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end
    // sticky overrun: a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_overrun <= 1'b0;
        else if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
        else if (clear_overrun) r_overrun <= 1'b0;
    end
    spi_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SPI_BITS)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: randomized scoreboard bench for spi_receiver against a byte-level reference model
module tb_spi_receiver;
    import spi_pkg::*;
    localparam int DEPTH = 4;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       spi_clk = 1'b1;
    logic       spi_data = 1'b0;
    logic       m_ready = 1'b0;
    logic       clear_overrun = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovr = 1'b0;
    int         fe_exp = 0;
    int         fe_rise = 0;
    int         fe_high = 0;
    bit         fe_prev = 1'b0;

    spi_receiver #(.SYNC_STAGES(2), .IDLE_TIMEOUT(16), .FIFO_DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .spi_clk       (spi_clk),
        .spi_data      (spi_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // monitor: every accepted byte is compared with the model's oldest expected byte
    always @(negedge clock) begin
        if (reset) begin
            if (frame_err && !fe_prev) fe_rise++;
            if (frame_err) fe_high++;
            fe_prev = frame_err;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected actual=0x%0h required=none", m_data);
                end else begin
                    chk("m_data", int'(m_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_clk = 1'b0;
            tick(1);
            spi_data = b[i];
            tick(SPI_SCK_HALF - 1);
            spi_clk = 1'b1;
            if (i != 0) tick(SPI_SCK_HALF);
        end
    endtask

    // mode 0: plain; mode 1: one pop timed onto the PUSH cycle; mode 2: latency check from empty
    task automatic send_byte(input logic [7:0] b, input int mode);
        int wait_cyc;
        send_bits(b, 8);
        if (exp_q.size() < DEPTH || mode == 1) exp_q.push_back(b);
        else exp_ovr = 1'b1;
        if (mode == 2) begin
            tick(2);
            chk("latency_early_valid", int'(m_valid), 0);
            wait_cyc = 2;
            while (!m_valid && wait_cyc < 8) begin
                tick(1);
                wait_cyc++;
            end
            chk("latency_valid_by_bound", int'(m_valid), 1);
            chk("latency_head_data", int'(m_data), int'(b));
            tick(SPI_SCK_HALF);
        end else if (mode == 1) begin
            tick(3);
            m_ready = 1'b1;
            tick(1);
            m_ready = 1'b0;
            tick(SPI_SCK_HALF - 3);
        end else begin
            tick(SPI_SCK_HALF);
        end
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && cyc < 40) begin
            tick(1);
            cyc++;
        end
        m_ready = 1'b0;
        chk("drain_complete", int'(exp_q.size() == 0 && !m_valid), 1);
    endtask

    task automatic clear_ovr();
        clear_overrun = 1'b1;
        tick(1);
        clear_overrun = 1'b0;
        exp_ovr = 1'b0;
        tick(1);
        chk("overrun_cleared", int'(overrun), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_m_data"}, int'(m_data), 0);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        int fe0;
        int fh0;
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b1;
        tick(4);

        // single byte with latency check
        send_byte(8'hA5, 2);
        chk("a5_overrun", int'(overrun), 0);
        drain(cyc);

        // four bytes fill the FIFO, then drain one per clock
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        chk("full_valid", int'(m_valid), 1);
        chk("full_no_overrun", int'(overrun), 0);
        drain(cyc);
        chk("drain_one_per_clock", cyc, 4);

        // five bytes: the fifth is dropped and overrun is sticky
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        tick(20);
        chk("overrun_set", int'(overrun), int'(exp_ovr));
        tick(20);
        chk("overrun_sticky", int'(overrun), 1);
        drain(cyc);
        chk("overrun_after_drain", int'(overrun), 1);
        clear_ovr();

        // full FIFO with a pop landing on the fifth byte's PUSH cycle
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        send_byte(8'h05, 1);
        tick(4);
        chk("push_pop_full_overrun", int'(overrun), int'(exp_ovr));
        drain(cyc);
        chk("push_pop_full_drain_cycles", cyc, 4);

        // truncated byte: three bits then clock held high
        fe0 = fe_rise;
        fh0 = fe_high;
        send_bits(8'hE0, 3);
        tick(2);
        chk("partial_busy", int'(busy), 1);
        tick(40);
        fe_exp++;
        chk("frame_err_pulses", fe_rise - fe0, 1);
        chk("frame_err_width", fe_high - fh0, 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(m_valid), 0);
        send_byte(8'h3C, 0);
        drain(cyc);

        // reset mid-byte with a byte already buffered
        send_byte(8'h77, 0);
        send_bits(8'hFF, 4);
        chk("midbyte_busy", int'(busy), 1);
        reset = 1'b0;
        tick(3);
        check_idle_outputs("midreset");
        exp_q.delete();
        exp_ovr = 1'b0;
        reset = 1'b1;
        tick(3);
        send_byte(8'h81, 0);
        drain(cyc);

        // random stream with an always-ready consumer
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom_range(0, 255)), 0);
            tick($urandom_range(0, 6));
        end
        tick(4);
        m_ready = 1'b0;
        chk("stream_queue_empty", exp_q.size(), 0);
        chk("stream_overrun", int'(overrun), 0);

        // random bursts against a stalled consumer
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 6 : int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 0);
            tick(4);
            chk("burst_overrun", int'(overrun), int'(exp_ovr));
            drain(cyc);
            clear_ovr();
        end

        chk("frame_err_total", fe_rise, fe_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
